// File: rtl/vc_pkg.sv
// rtl/vc_pkg.sv - shared defaults, constants and state type for the victim cache controller
package vc_pkg;

  localparam int TAG_WIDTH        = 24;
  localparam int VC_SIZE          = 8;
  localparam int NUM_MUX_SEL_BITS = 4;

  // Tag-store select value reported when no entry compares equal
  localparam logic [NUM_MUX_SEL_BITS-1:0] MISS_SEL = NUM_MUX_SEL_BITS'(1 << (NUM_MUX_SEL_BITS - 1));

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    SWAP,
    WB,
    INSTALL,
    RESP
  } vc_state_e;

endpackage

// File: rtl/vc_if.sv
// rtl/vc_if.sv - L1, tag/data store and L2 write-back signals of the victim cache controller
interface vc_if import vc_pkg::*; #(
  parameter int tag_width        = TAG_WIDTH,
  parameter int vc_size          = VC_SIZE,
  parameter int num_mux_sel_bits = NUM_MUX_SEL_BITS
);

  logic                        l1_req;
  logic [tag_width-1:0]        l1_req_tag;
  logic                        l1_evict;
  logic [tag_width-1:0]        l1_evict_tag;
  logic                        l1_evict_dirty;
  logic                        l1_resp;
  logic                        vc_hit;
  logic                        vc_hit_dirty;
  logic                        vc_tag_cmp;
  logic                        vc_tag_write;
  logic [vc_size-1:0]          vc_tag_store_ld_mask;
  logic [tag_width-1:0]        vc_tag_store_datain;
  logic [num_mux_sel_bits-1:0] vc_datamux_sel;
  logic                        vc_data_write;
  logic                        l2_wb_req;
  logic [tag_width-1:0]        l2_wb_tag;
  logic                        l2_wb_ack;

  modport slave (
    input  l1_req, l1_req_tag, l1_evict, l1_evict_tag, l1_evict_dirty,
    input  vc_datamux_sel, l2_wb_ack,
    output l1_resp, vc_hit, vc_hit_dirty,
    output vc_tag_cmp, vc_tag_write, vc_tag_store_ld_mask, vc_tag_store_datain,
    output vc_data_write, l2_wb_req, l2_wb_tag
  );

  modport master (
    output l1_req, l1_req_tag, l1_evict, l1_evict_tag, l1_evict_dirty,
    output vc_datamux_sel, l2_wb_ack,
    input  l1_resp, vc_hit, vc_hit_dirty,
    input  vc_tag_cmp, vc_tag_write, vc_tag_store_ld_mask, vc_tag_store_datain,
    input  vc_data_write, l2_wb_req, l2_wb_tag
  );

endinterface

// File: rtl/vc_victim_sel.sv
// rtl/vc_victim_sel.sv - picks the install slot: lowest invalid entry, else the FIFO pointer
module vc_victim_sel import vc_pkg::*; #(
  parameter int vc_size = VC_SIZE,
  localparam int idx_w  = $clog2(vc_size)
) (
  input  logic [vc_size-1:0] valid,
  input  logic [idx_w-1:0]   fifo_ptr,
  output logic [idx_w-1:0]   victim_idx,
  output logic [vc_size-1:0] victim_mask,
  output logic               use_ptr
);

  // Scan from the top so the lowest invalid index is the one left standing
  always_comb begin
    victim_idx = fifo_ptr;
    use_ptr    = 1'b1;
    for (int i = vc_size - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim_idx = idx_w'(i);
        use_ptr    = 1'b0;
      end
    end
    victim_mask = vc_size'(1) << victim_idx;
  end

endmodule

// File: rtl/vc_control.sv
// rtl/vc_control.sv - victim cache lookup/swap/install controller with dirty write-back to L2
module vc_control import vc_pkg::*; #(
  parameter int tag_width        = TAG_WIDTH,
  parameter int vc_size          = VC_SIZE,
  parameter int num_mux_sel_bits = NUM_MUX_SEL_BITS
) (
  input logic  clk,
  input logic  rst,
  vc_if.slave  bus
);

  localparam int idx_w = $clog2(vc_size);

  vc_state_e            state, state_nxt;
  logic [vc_size-1:0]   valid, dirty;
  logic [tag_width-1:0] tags [vc_size];
  logic [idx_w-1:0]     fifo_ptr, fifo_ptr_inc, hit_idx;
  logic                 hit_q, hit_dirty_q;
  logic [tag_width-1:0] req_tag_q, evict_tag_q;
  logic                 evict_q, evict_dirty_q;

  logic [idx_w-1:0]     victim_idx;
  logic [vc_size-1:0]   victim_mask;
  logic                 use_ptr;
  logic [idx_w-1:0]     sel_idx;
  logic                 cmp_hit;

  assign sel_idx      = bus.vc_datamux_sel[idx_w-1:0];
  assign cmp_hit      = !bus.vc_datamux_sel[num_mux_sel_bits-1] && valid[sel_idx];
  assign fifo_ptr_inc = (fifo_ptr == idx_w'(vc_size - 1)) ? '0 : fifo_ptr + idx_w'(1);

  vc_victim_sel #(.vc_size(vc_size)) u_victim_sel (
    .valid       (valid),
    .fifo_ptr    (fifo_ptr),
    .victim_idx  (victim_idx),
    .victim_mask (victim_mask),
    .use_ptr     (use_ptr)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt                = state;
    bus.l1_resp              = 1'b0;
    bus.vc_hit               = 1'b0;
    bus.vc_hit_dirty         = 1'b0;
    bus.vc_tag_cmp           = 1'b0;
    bus.vc_tag_write         = 1'b0;
    bus.vc_data_write        = 1'b0;
    bus.vc_tag_store_ld_mask = '0;
    bus.vc_tag_store_datain  = '0;
    bus.l2_wb_req            = 1'b0;
    bus.l2_wb_tag            = '0;
    unique case (state)
      IDLE: begin
        if (bus.l1_req) state_nxt = CMP;
      end
      CMP: begin
        bus.vc_tag_cmp          = 1'b1;
        bus.vc_tag_store_datain = req_tag_q;
        if (cmp_hit)                                   state_nxt = SWAP;
        else if (!evict_q)                             state_nxt = RESP;
        else if (valid[victim_idx] && dirty[victim_idx]) state_nxt = WB;
        else                                           state_nxt = INSTALL;
      end
      SWAP: begin
        bus.vc_tag_store_ld_mask = vc_size'(1) << hit_idx;
        if (evict_q) begin
          bus.vc_tag_write        = 1'b1;
          bus.vc_data_write       = 1'b1;
          bus.vc_tag_store_datain = evict_tag_q;
        end
        state_nxt = RESP;
      end
      WB: begin
        // Victim slot is stable while waiting: valid and pointer only move in SWAP/INSTALL
        bus.l2_wb_req = 1'b1;
        bus.l2_wb_tag = tags[victim_idx];
        if (bus.l2_wb_ack) state_nxt = INSTALL;
      end
      INSTALL: begin
        bus.vc_tag_store_ld_mask = victim_mask;
        bus.vc_tag_write         = 1'b1;
        bus.vc_data_write        = 1'b1;
        bus.vc_tag_store_datain  = evict_tag_q;
        state_nxt                = RESP;
      end
      RESP: begin
        bus.l1_resp      = 1'b1;
        bus.vc_hit       = hit_q;
        bus.vc_hit_dirty = hit_dirty_q;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid         <= '0;
      dirty         <= '0;
      fifo_ptr      <= '0;
      hit_idx       <= '0;
      hit_q         <= 1'b0;
      hit_dirty_q   <= 1'b0;
      req_tag_q     <= '0;
      evict_q       <= 1'b0;
      evict_tag_q   <= '0;
      evict_dirty_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.l1_req) begin
            req_tag_q     <= bus.l1_req_tag;
            evict_q       <= bus.l1_evict;
            evict_tag_q   <= bus.l1_evict_tag;
            evict_dirty_q <= bus.l1_evict_dirty;
          end
        end
        CMP: begin
          hit_q       <= cmp_hit;
          hit_dirty_q <= cmp_hit && dirty[sel_idx];
          hit_idx     <= sel_idx;
        end
        SWAP: begin
          if (evict_q) dirty[hit_idx] <= evict_dirty_q;
          else         valid[hit_idx] <= 1'b0;
        end
        INSTALL: begin
          valid[victim_idx] <= 1'b1;
          dirty[victim_idx] <= evict_dirty_q;
          if (use_ptr) fifo_ptr <= fifo_ptr_inc;
        end
        default: ;
      endcase
    end
  end

  // Internal tag copy feeds l2_wb_tag; entries are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (state == INSTALL)            tags[victim_idx] <= evict_tag_q;
    else if (state == SWAP && evict_q) tags[hit_idx]  <= evict_tag_q;
  end

endmodule

// File: tb/tb_vc_control.sv
// tb/tb_vc_control.sv - directed-vector bench for vc_control
module tb_vc_control;
  import vc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vc_if bus ();

  vc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  int          o_resp, o_wr_cyc, o_wb_cycles;
  logic        o_hit, o_hit_dirty, o_cmp, o_dw_ok, o_wb_stable;
  logic [7:0]  o_mask;
  logic [23:0] o_data, o_wb_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                = 1'b0;
    bus.l1_req         = 1'b0;
    bus.l1_req_tag     = '0;
    bus.l1_evict       = 1'b0;
    bus.l1_evict_tag   = '0;
    bus.l1_evict_dirty = 1'b0;
    bus.vc_datamux_sel = 4'h8;
    bus.l2_wb_ack      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_strobes"}, 32'({bus.l1_resp, bus.vc_hit, bus.vc_hit_dirty, bus.vc_tag_cmp,
                                 bus.vc_tag_write, bus.vc_data_write, bus.l2_wb_req}), 32'h0);
    check({pfx, "_mask"}, 32'(bus.vc_tag_store_ld_mask), 32'h0);
    check({pfx, "_datain"}, 32'(bus.vc_tag_store_datain), 32'h0);
    check({pfx, "_wbtag"}, 32'(bus.l2_wb_tag), 32'h0);
  endtask

  // One lookup; cycle 1 is the cycle right after the accepting edge
  task automatic txn(input logic [23:0] tag, input logic ev, input logic [23:0] etag,
                     input logic ed, input logic [3:0] sel, input int ack_at);
    @(negedge clk);
    bus.l1_req = 1'b1; bus.l1_req_tag = tag; bus.l1_evict = ev;
    bus.l1_evict_tag = etag; bus.l1_evict_dirty = ed; bus.vc_datamux_sel = sel;
    o_resp = -1; o_wr_cyc = -1; o_wb_cycles = 0; o_mask = '0; o_data = '0; o_wb_tag = '0;
    o_hit = 1'b0; o_hit_dirty = 1'b0; o_cmp = 1'b0; o_dw_ok = 1'b1; o_wb_stable = 1'b1;
    @(posedge clk); #1;
    bus.l1_req_tag = ~tag; bus.l1_evict = ~ev; bus.l1_evict_tag = ~etag; bus.l1_evict_dirty = ~ed;
    for (int c = 1; c <= 40; c++) begin
      bus.l2_wb_ack = (c == 1);
      if (c == 1) o_cmp = bus.vc_tag_cmp && (bus.vc_tag_store_datain == tag);
      if (bus.vc_data_write !== bus.vc_tag_write) o_dw_ok = 1'b0;
      if (bus.vc_tag_write) begin
        o_wr_cyc = c; o_mask = bus.vc_tag_store_ld_mask; o_data = bus.vc_tag_store_datain;
      end
      if (bus.l2_wb_req) begin
        if (o_wb_cycles > 0 && bus.l2_wb_tag !== o_wb_tag) o_wb_stable = 1'b0;
        o_wb_tag = bus.l2_wb_tag;
        o_wb_cycles++;
        if (o_wb_cycles == ack_at) bus.l2_wb_ack = 1'b1;
      end
      if (bus.l1_resp) begin
        o_resp = c; o_hit = bus.vc_hit; o_hit_dirty = bus.vc_hit_dirty;
        break;
      end
      @(posedge clk); #1;
    end
    bus.l1_req = 1'b0; bus.l2_wb_ack = 1'b0;
    @(posedge clk);
  endtask

  task automatic fill(input logic [23:0] base, input logic [7:0] dmask, input string nm);
    for (int k = 0; k < 8; k++) begin
      txn(base + 24'(k), 1'b1, base + 24'(k), dmask[k], 4'h8, 0);
      check($sformatf("%s%0d_mask", nm, k), 32'(o_mask), 32'(8'h01 << k));
      check($sformatf("%s%0d_data", nm, k), 32'(o_data), 32'(base + 24'(k)));
      check($sformatf("%s%0d_resp", nm, k), 32'(o_resp), 32'd3);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic resp_seen;
    int   waited;

    do_reset();
    #1;
    check_quiet("reset");

    txn(24'hABC, 1'b0, 24'h0, 1'b0, 4'h8, 0);
    check("abc_cmp",    32'(o_cmp), 32'd1);
    check("abc_resp",   32'(o_resp), 32'd2);
    check("abc_hit",    32'(o_hit), 32'd0);
    check("abc_nowr",   32'(o_wr_cyc), 32'hFFFF_FFFF);

    fill(24'd1, 8'h00, "inst");

    txn(24'd9, 1'b1, 24'd9, 1'b0, 4'h8, 0);
    check("inst9_mask", 32'(o_mask), 32'h01);
    check("inst9_resp", 32'(o_resp), 32'd3);
    check("inst9_nowb", 32'(o_wb_cycles), 32'd0);
    txn(24'd10, 1'b1, 24'd10, 1'b0, 4'h8, 0);
    check("inst10_mask", 32'(o_mask), 32'h02);

    txn(24'd3, 1'b1, 24'h55, 1'b1, 4'h2, 0);
    check("hit3_wrcyc", 32'(o_wr_cyc), 32'd2);
    check("hit3_mask",  32'(o_mask), 32'h04);
    check("hit3_data",  32'(o_data), 32'h55);
    check("hit3_resp",  32'(o_resp), 32'd3);
    check("hit3_hit",   32'(o_hit), 32'd1);
    check("hit3_hitd",  32'(o_hit_dirty), 32'd0);
    check("hit3_dw",    32'(o_dw_ok), 32'd1);

    txn(24'h55, 1'b0, 24'h0, 1'b0, 4'h2, 0);
    check("hit55_hit",  32'(o_hit), 32'd1);
    check("hit55_hitd", 32'(o_hit_dirty), 32'd1);
    check("hit55_nowr", 32'(o_wr_cyc), 32'hFFFF_FFFF);
    check("hit55_resp", 32'(o_resp), 32'd3);

    txn(24'h55, 1'b0, 24'h0, 1'b0, 4'h2, 0);
    check("inv2_hit",   32'(o_hit), 32'd0);
    check("inv2_resp",  32'(o_resp), 32'd2);

    txn(24'h66, 1'b1, 24'h66, 1'b0, 4'h8, 0);
    check("hole_mask",  32'(o_mask), 32'h04);
    txn(24'h77, 1'b1, 24'h77, 1'b0, 4'h8, 0);
    check("ptr2_mask",  32'(o_mask), 32'h04);
    check("ptr2_resp",  32'(o_resp), 32'd3);

    do_reset();
    fill(24'h101, 8'h01, "wbfill");
    txn(24'h200, 1'b1, 24'h200, 1'b0, 4'h8, 5);
    check("wb_cycles",  32'(o_wb_cycles), 32'd5);
    check("wb_tag",     32'(o_wb_tag), 32'h101);
    check("wb_stable",  32'(o_wb_stable), 32'd1);
    check("wb_wrcyc",   32'(o_wr_cyc), 32'd7);
    check("wb_mask",    32'(o_mask), 32'h01);
    check("wb_data",    32'(o_data), 32'h200);
    check("wb_resp",    32'(o_resp), 32'd8);

    do_reset();
    fill(24'h301, 8'hFF, "rstfill");
    @(negedge clk);
    bus.l1_req = 1'b1; bus.l1_req_tag = 24'h400; bus.l1_evict = 1'b1;
    bus.l1_evict_tag = 24'h400; bus.l1_evict_dirty = 1'b0; bus.vc_datamux_sel = 4'h8;
    bus.l2_wb_ack = 1'b0;
    waited = 0;
    @(posedge clk); #1;
    while (!bus.l2_wb_req && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rstwb_req", 32'(bus.l2_wb_req), 32'd1);
    check("rstwb_tag", 32'(bus.l2_wb_tag), 32'h301);
    @(negedge clk);
    rst = 1'b0; bus.l1_req = 1'b0;
    @(posedge clk); #1;
    check_quiet("rstwb");
    @(negedge clk);
    rst = 1'b1;
    resp_seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.l1_resp) resp_seen = 1'b1;
    end
    check("rstwb_noresp", 32'(resp_seen), 32'd0);
    txn(24'h301, 1'b0, 24'h0, 1'b0, 4'h0, 0);
    check("rstwb_lkhit",  32'(o_hit), 32'd0);
    check("rstwb_lkresp", 32'(o_resp), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vc_control.md
VC_CONTROL -- requirements
Module: vc_control

Interface
REQ-001 Parameters: tag_width, 24, tag bits; vc_size, 8, entries; num_mux_sel_bits, 4, tag-store select width (MSB set = miss).
REQ-002 clk  in  1  sole clock; all state changes on posedge.
REQ-003 rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-004 l1_req  in  1  L1 miss lookup request; held until l1_resp.
REQ-005 l1_req_tag  in  tag_width  tag being looked up.
REQ-006 l1_evict  in  1  L1 supplies a victim line with this request.
REQ-007 l1_evict_tag  in  tag_width; l1_evict_dirty  in  1  victim tag and dirty flag.
REQ-008 l1_resp  out  1  one-cycle completion pulse; vc_hit  out  1  and vc_hit_dirty  out  1  are valid with it.
REQ-009 vc_tag_cmp  out  1; vc_tag_write  out  1; vc_tag_store_ld_mask  out  vc_size; vc_tag_store_datain  out  tag_width  drive the tag store.
REQ-010 vc_datamux_sel  in  num_mux_sel_bits  combinational tag-store compare result.
REQ-011 vc_data_write  out  1  data-store write strobe, uses vc_tag_store_ld_mask.
REQ-012 l2_wb_req  out  1; l2_wb_tag  out  tag_width; l2_wb_ack  in  1  dirty write-back handshake.

Function
REQ-013 FSM states: IDLE, CMP, SWAP, WB, INSTALL, RESP.
REQ-014 IDLE: on l1_req=1 register l1_req_tag, l1_evict, l1_evict_tag, l1_evict_dirty; go CMP.
REQ-015 CMP: vc_tag_cmp=1, datain=registered req tag; hit = sel MSB 0 AND valid[sel]; register hit index.
REQ-016 CMP transitions: hit -> SWAP; miss and no evict -> RESP; miss with evict -> victim slot chosen, slot valid&dirty -> WB, else INSTALL.
REQ-017 Victim slot: lowest-index invalid entry; if none, FIFO pointer entry.
REQ-018 SWAP: one-hot mask at hit index; with evict: vc_tag_write=vc_data_write=1, datain=evict tag, dirty[idx]=evict_dirty; without evict: no write, valid[idx]=0.
REQ-019 WB: l2_wb_req=1, l2_wb_tag=victim slot tag (internal copy), held stable until l2_wb_ack=1 sampled; then INSTALL.
REQ-020 INSTALL: one-hot mask at victim slot, vc_tag_write=vc_data_write=1, datain=evict tag; valid=1, dirty=evict_dirty; FIFO pointer +1 mod vc_size only if pointer slot was used.
REQ-021 RESP: l1_resp=1 one cycle, vc_hit and vc_hit_dirty (pre-swap dirty of hit entry) valid; return IDLE; new l1_req accepted no earlier than next cycle.
REQ-022 Latency from l1_req sampled in IDLE (cycle 0) to l1_resp: hit 3; miss no evict 2; miss clean install 3; dirty = 3 + cycles to l2_wb_ack inclusive.
REQ-023 Outside named states all strobes 0, mask 0, datain 0; l2_wb_ack outside WB ignored.
REQ-024 Request inputs changing after acceptance have no effect.

Reset
REQ-025 rst=0 at posedge: state IDLE, all valid and dirty 0, FIFO pointer 0, all outputs 0, including mid-WB (l2_wb_req drops next cycle) and mid-operation (no l1_resp).

Structure
REQ-026 vc_pkg holds state enum, tag_width/vc_size/num_mux_sel_bits defaults, MISS_SEL constant.
REQ-027 Sub-module vc_victim_sel: valid vector + FIFO pointer -> victim index, one-hot mask.

Verification
REQ-028 Reset, l1_req tag 0xABC, no evict, sel=8 -> l1_resp cycle 2, vc_hit=0, no tag write.
REQ-029 Eight clean installs tags 1..8 -> masks 0x01..0x80 in order; ninth install tag 9 -> mask 0x01, pointer 1.
REQ-030 Hit on tag 3 (sel=2) with evict tag 0x55 dirty -> cycle 2 mask 0x04 write datain 0x55; l1_resp cycle 3, vc_hit=1.
REQ-031 Full cache, slot 0 dirty, install: l2_wb_req with l2_wb_tag=slot-0 tag, ack after 5 cycles -> INSTALL next, l1_resp one cycle later.
REQ-032 rst=0 during WB -> next cycle all outputs 0, subsequent lookup of former tags misses.
